// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution engine: width arithmetic,
// default-configuration constants and the output saturation function.
package conv_pkg;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits = bits + 1;
        return bits;
    endfunction

    function automatic int num_taps(input int k);
        return k * k;
    endfunction

    // Products are pre-shifted by the fraction bits, so the accumulator only
    // needs headroom for the tap count plus the bias term.
    function automatic int acc_width(input int dw, input int fb, input int k);
        return dw + fb + clog2(k * k + 1);
    endfunction

    localparam int NUM_TAPS  = num_taps(5);
    localparam int ACC_W     = acc_width(16, 8, 5);
    localparam int BIAS_ADDR = NUM_TAPS;

    function automatic longint sat(input longint value, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - 1;
        lo = -(longint'(1) <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/line_window_buffer.sv
// K-1 circular line memories feeding a KxK shift window; everything advances
// only on shift_en, so stalls on the pixel stream leave the contents intact.
module line_window_buffer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   shift_en,
    input  logic [DATA_WIDTH-1:0]                                  pixel_in,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]     window
);
    localparam int K  = KERNEL_SIZE;
    localparam int N  = IMAGE_SIZE;
    localparam int PW = clog2(N);

    logic [DATA_WIDTH-1:0]           line_mem [K-1][N];
    logic [K-1:0][DATA_WIDTH-1:0]    col_in;
    logic [K*K-1:0][DATA_WIDTH-1:0]  win_q, win_d;
    logic [PW-1:0]                   ptr_q, ptr_d;

    // Row i of the incoming column is the pixel (K-1-i) lines older; each
    // memory is read at the pointer before being overwritten with the row below.
    always_comb begin
        col_in = '0;
        col_in[K-1] = pixel_in;
        for (int i = 0; i < K - 1; i++) col_in[i] = line_mem[i][ptr_q];

        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == K - 1) win_d[r*K+c] = col_in[r];
                    else            win_d[r*K+c] = win_q[r*K+c+1];
                end
            end
        end

        ptr_d = ptr_q;
        if (shift_en) ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < K - 1; i++) line_mem[i][ptr_q] <= col_in[i+1];
        end
        win_q <= win_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign window = win_q;

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution: raster pixel input with valid/ready, edge-gated
// windows, three-stage multiply / accumulate / saturate pipeline.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BIT    = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int IMAGE_SIZE  = 28,
    parameter int RELU_EN     = 0
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                weight_write,
    input  logic [clog2(KERNEL_SIZE*KERNEL_SIZE+1)-1:0]         weight_addr,
    input  logic signed [DATA_WIDTH-1:0]                        weight_data,
    output logic                                                weight_err,
    input  logic                                                pixel_valid,
    output logic                                                pixel_ready,
    input  logic signed [DATA_WIDTH-1:0]                        pixel_input,
    output logic                                                out_valid,
    output logic signed [DATA_WIDTH-1:0]                        out_data,
    output logic                                                frame_done,
    output logic                                                busy
);
    localparam int K      = KERNEL_SIZE;
    localparam int N      = IMAGE_SIZE;
    localparam int TAPS   = num_taps(K);
    localparam int AW     = clog2(TAPS + 1);
    localparam int CW     = clog2(N);
    localparam int SUM_W  = acc_width(DATA_WIDTH, FRAC_BIT, K);
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic [TAPS-1:0][DATA_WIDTH-1:0] window;
    logic                            accept, wr_ok;
    logic signed [PROD_W-1:0]        full;
    longint                          sat_v;

    logic [CW-1:0]                col_q, col_d, row_q, row_d;
    logic signed [DATA_WIDTH-1:0] weight_q [TAPS];
    logic signed [DATA_WIDTH-1:0] weight_d [TAPS];
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic signed [SUM_W-1:0]      prod_q [TAPS];
    logic signed [SUM_W-1:0]      prod_d [TAPS];
    logic signed [SUM_W-1:0]      acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic v0_q, v0_d, v1_q, v2_q, out_valid_q;
    logic l0_q, l0_d, l1_q, l2_q, frame_done_q;
    logic err_q, err_d, busy_q, busy_d;

    assign pixel_ready = ~weight_write;
    assign accept      = pixel_valid & pixel_ready;

    line_window_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE),
        .IMAGE_SIZE (IMAGE_SIZE)
    ) u_lwb (
        .clk     (clk),
        .reset   (reset),
        .shift_en(accept),
        .pixel_in(pixel_input),
        .window  (window)
    );

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == CW'(N - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(N - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        // Only windows lying fully inside the current frame are launched.
        v0_d = accept && (row_q >= CW'(K - 1)) && (col_q >= CW'(K - 1));
        l0_d = accept && (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));
        busy_d = (col_d != '0) || (row_d != '0) || l0_d || l0_q || l1_q || l2_q;

        wr_ok = weight_write && !busy_q && (weight_addr <= AW'(TAPS));
        err_d = weight_write && !wr_ok;
        for (int i = 0; i < TAPS; i++)
            weight_d[i] = (wr_ok && weight_addr == AW'(i)) ? weight_data : weight_q[i];
        bias_d = (wr_ok && weight_addr == AW'(TAPS)) ? weight_data : bias_q;

        full = '0;
        for (int i = 0; i < TAPS; i++) begin
            full      = PROD_W'($signed(window[i])) * PROD_W'(weight_q[i]);
            prod_d[i] = SUM_W'(full >>> FRAC_BIT);
        end

        acc_d = SUM_W'(bias_q);
        for (int i = 0; i < TAPS; i++) acc_d = acc_d + prod_q[i];

        sat_v = sat(longint'(acc_q), DATA_WIDTH);
        if (RELU_EN != 0 && sat_v < 0) sat_v = 0;
        out_data_d = v2_q ? DATA_WIDTH'(sat_v) : out_data_q;
    end

    // Pipeline stages run freely once launched; input stalls only gate v0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            bias_q       <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            {v0_q, v1_q, v2_q, out_valid_q}   <= '0;
            {l0_q, l1_q, l2_q, frame_done_q}  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                weight_q[i] <= '0;
                prod_q[i]   <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            bias_q       <= bias_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            v0_q         <= v0_d;
            v1_q         <= v0_q;
            v2_q         <= v1_q;
            out_valid_q  <= v2_q;
            l0_q         <= l0_d;
            l1_q         <= l0_q;
            l2_q         <= l1_q;
            frame_done_q <= l2_q;
            err_q        <= err_d;
            busy_q       <= busy_d;
            for (int i = 0; i < TAPS; i++) begin
                weight_q[i] <= weight_d[i];
                prod_q[i]   <= prod_d[i];
            end
        end
    end

    assign weight_err = err_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine (K=3, N=5): a plain and a ReLU instance share
// inputs; a reference model pushes expected results, the monitor pops them.
module tb_conv_stream_engine;
    localparam int DW   = 16;
    localparam int FB   = 8;
    localparam int K    = 3;
    localparam int N    = 5;
    localparam int AW   = 4;
    localparam int TAPS = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 weight_write = 1'b0;
    logic                 pixel_valid = 1'b0;
    logic [AW-1:0]        weight_addr = '0;
    logic signed [DW-1:0] weight_data = '0;
    logic signed [DW-1:0] pixel_input = '0;
    logic                 weight_err, pixel_ready, out_valid, frame_done, busy;
    logic signed [DW-1:0] out_data;
    logic                 weight_err_r, pixel_ready_r, out_valid_r, frame_done_r, busy_r;
    logic signed [DW-1:0] out_data_r;

    typedef struct {
        longint value;
        bit     last;
        time    t_acc;
    } exp_t;

    typedef struct {
        bit            ww;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            pv;
        bit            exp_err;
    } vec_t;

    exp_t                 sb_q[$];
    exp_t                 mon_e;
    vec_t                 vecs[6];
    int                   total = 0;
    int                   bad = 0;
    int                   out_cnt = 0;
    int                   fd_cnt = 0;
    int                   c0, f0;
    logic signed [DW-1:0] w_m[TAPS];
    logic signed [DW-1:0] bias_m;
    logic signed [DW-1:0] pix_m[N][N];
    int                   mrow = 0;
    int                   mcol = 0;

    always #5 clk = ~clk;

    conv_stream_engine #(
        .DATA_WIDTH(DW), .FRAC_BIT(FB), .KERNEL_SIZE(K), .IMAGE_SIZE(N), .RELU_EN(0)
    ) dut (
        .clk(clk), .reset(reset), .weight_write(weight_write), .weight_addr(weight_addr),
        .weight_data(weight_data), .weight_err(weight_err), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .pixel_input(pixel_input), .out_valid(out_valid),
        .out_data(out_data), .frame_done(frame_done), .busy(busy)
    );

    conv_stream_engine #(
        .DATA_WIDTH(DW), .FRAC_BIT(FB), .KERNEL_SIZE(K), .IMAGE_SIZE(N), .RELU_EN(1)
    ) dut_relu (
        .clk(clk), .reset(reset), .weight_write(weight_write), .weight_addr(weight_addr),
        .weight_data(weight_data), .weight_err(weight_err_r), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready_r), .pixel_input(pixel_input), .out_valid(out_valid_r),
        .out_data(out_data_r), .frame_done(frame_done_r), .busy(busy_r)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint model_window();
        longint acc;
        acc = longint'(bias_m);
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                acc += (longint'(pix_m[mrow-K+1+i][mcol-K+1+j]) * longint'(w_m[i*K+j])) >>> FB;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic logic signed [DW-1:0] pixel_for(input int mode, input int r, input int c);
        if (mode == 0) return 16'sh0100;
        if (mode == 1) return DW'((N * r + c) * 256);
        return 16'sh7FFF;
    endfunction

    // One clock of stimulus; the model tracks writes and accepts at the edge.
    task automatic applyStimulus(input bit pv, input logic signed [DW-1:0] px, input bit ww,
                                 input logic [AW-1:0] wa, input logic signed [DW-1:0] wd,
                                 input bit exp_err);
        time t_edge;
        pixel_valid  = pv;
        pixel_input  = px;
        weight_write = ww;
        weight_addr  = wa;
        weight_data  = wd;
        #1;
        checkOutput("pixel_ready", {pixel_ready, pixel_ready_r}, ww ? 0 : 3);
        @(posedge clk);
        t_edge = $time;
        if (ww && !exp_err) begin
            if (int'(wa) == TAPS) bias_m = wd;
            else w_m[int'(wa)] = wd;
        end else if (pv && !ww) begin
            pix_m[mrow][mcol] = px;
            if (mrow >= K - 1 && mcol >= K - 1)
                sb_q.push_back('{model_window(), (mrow == N - 1 && mcol == N - 1), t_edge});
            if (mcol == N - 1) begin
                mcol = 0;
                mrow = (mrow == N - 1) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
        #1;
        checkOutput("weight_err", {weight_err, weight_err_r}, (ww && exp_err) ? 3 : 0);
    endtask

    task automatic run_frame(input int mode, input bit rnd, input int first, input int stop);
        int idx;
        int guard;
        bit pv;
        idx = first;
        guard = 0;
        while (idx < stop && guard < 1000) begin
            pv = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(pv, pixel_for(mode, idx / N, idx % N), 1'b0, '0, '0, 1'b0);
            if (pv) idx++;
            guard++;
        end
        checkOutput("frame_accepts", idx, stop);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 100) begin
            applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
            n++;
        end
        checkOutput("drain_timeout", (busy || sb_q.size() != 0), 0);
    endtask

    task automatic load_weights(input logic signed [DW-1:0] other, input logic signed [DW-1:0] centre,
                                input logic signed [DW-1:0] b);
        for (int a = 0; a < TAPS; a++)
            applyStimulus(1'b0, '0, 1'b1, AW'(a), (a == 4) ? centre : other, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, AW'(TAPS), b, 1'b0);
    endtask

    task automatic frame_check(input int mode, input bit rnd);
        c0 = out_cnt;
        f0 = fd_cnt;
        run_frame(mode, rnd, 0, N * N);
        wait_idle();
        checkOutput("frame_outputs", out_cnt - c0, 9);
        checkOutput("frame_done_count", fd_cnt - f0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pixel_valid = 1'b0;
        weight_write = 1'b0;
        #1;
        checkOutput("reset_busy", {busy, busy_r}, 0);
        checkOutput("reset_out_valid", {out_valid, out_valid_r}, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_weight_err", weight_err, 0);
        sb_q.delete();
        mrow = 0;
        mcol = 0;
        for (int i = 0; i < TAPS; i++) w_m[i] = '0;
        bias_m = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got data %0d, expected no output at t=%0t",
                             out_data, $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("out_data", out_data, mon_e.value);
                    checkOutput("out_data_relu", out_data_r, (mon_e.value < 0) ? 0 : mon_e.value);
                    checkOutput("out_valid_relu", out_valid_r, 1);
                    checkOutput("frame_done", {frame_done, frame_done_r}, mon_e.last ? 3 : 0);
                    checkOutput("latency", longint'($time - mon_e.t_acc), 35);
                end
            end else if (frame_done) begin
                total++;
                bad++;
                $display("[TB] FAIL stray_frame_done: got 1, expected 0 at t=%0t", $time);
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd10, 16'h1234, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 4'd15, 16'h1111, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 4'd4,  16'h0100, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'd9,  16'h0080, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'd12, 16'h0000, 1'b0, 1'b1};

        do_reset();
        checkOutput("idle_ready", {pixel_ready, pixel_ready_r}, 3);

        $display("[TB] idle weight-port vectors");
        for (int v = 0; v < 6; v++)
            applyStimulus(vecs[v].pv, 16'sh0100, vecs[v].ww, vecs[v].addr,
                          vecs[v].data, vecs[v].exp_err);

        $display("[TB] ramp frame with table-loaded centre weight and bias");
        frame_check(1, 1'b0);

        $display("[TB] all-ones frame");
        load_weights(16'sh0100, 16'sh0100, 16'sh0000);
        frame_check(0, 1'b0);

        $display("[TB] saturation frames");
        load_weights(16'sh7FFF, 16'sh7FFF, 16'sh0000);
        frame_check(2, 1'b0);
        load_weights(16'sh8000, 16'sh8000, 16'sh0000);
        frame_check(2, 1'b0);

        $display("[TB] ramp frame with random pixel_valid");
        load_weights(16'sh0000, 16'sh0100, 16'sh0080);
        frame_check(1, 1'b1);

        $display("[TB] writes rejected while busy");
        c0 = out_cnt;
        run_frame(1, 1'b0, 0, 14);
        checkOutput("busy_mid_frame", {busy, busy_r}, 3);
        applyStimulus(1'b1, 16'sh0100, 1'b1, 4'd4, 16'sh0200, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 4'd9, 16'sh0300, 1'b1);
        run_frame(1, 1'b0, 14, N * N);
        wait_idle();
        checkOutput("busy_frame_outputs", out_cnt - c0, 9);

        $display("[TB] write accepted over pixel_valid when idle");
        applyStimulus(1'b1, 16'sh0100, 1'b1, 4'd4, 16'sh0200, 1'b0);
        frame_check(1, 1'b0);

        $display("[TB] reset mid-frame then replay");
        run_frame(1, 1'b0, 0, 12);
        checkOutput("busy_before_reset", busy, 1);
        do_reset();
        frame_check(1, 1'b0);

        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
